// File: rtl/key_capture.sv
// Note-key capture: synchronized/debounced keys and octave buttons feed an
// IDLE/HOLD/EMIT recorder that emits one timestamped, length-quantized note.

module key_capture_deb #(
   parameter int W   = 1,
   parameter int CYC = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw_i,
   output logic [W-1:0] deb_o
);
   localparam int CNT_W = $clog2(CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYC);

   logic [W-1:0]     s1_q, s2_q, cand_q, deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // cnt counts consecutive samples equal to cand; the vector is accepted once it reaches CYC
   always_comb begin
      cnt_d = CNT_W'(1);
      if (s2_q == cand_q)
         cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
      deb_d = (cnt_d == CNT_MAX) ? s2_q : deb_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         deb_q  <= '0;
      end else begin
         s1_q   <= raw_i;
         s2_q   <= s1_q;
         cand_q <= s2_q;
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign deb_o = deb_q;
endmodule

module key_capture #(
   parameter int NOTE_KEYS    = 7,
   parameter int NOTE_BITS    = 3,
   parameter int OCTAVE_BITS  = 3,
   parameter int LENGTH_BITS  = 3,
   parameter int CLOCK_BITS   = 32,
   parameter int DEBOUNCE_CYC = 2000000,
   parameter int TICK_CYC     = 12500000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   oct_up,
   input  logic                   oct_down,
   input  logic [NOTE_KEYS-1:0]   note_key,
   input  logic [CLOCK_BITS-1:0]  system_clock,
   output logic                   note_valid,
   output logic [CLOCK_BITS-1:0]  note_clock,
   output logic [OCTAVE_BITS-1:0] octave,
   output logic [OCTAVE_BITS-1:0] note_octave,
   output logic [NOTE_BITS-1:0]   note,
   output logic [LENGTH_BITS-1:0] length,
   output logic                   holding
);
   localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [TICK_W-1:0]      TICK_LAST = TICK_W'(TICK_CYC - 1);
   localparam logic [OCTAVE_BITS-1:0] OCT_MID   = OCTAVE_BITS'(4);
   localparam logic [OCTAVE_BITS-1:0] OCT_MAX   = OCTAVE_BITS'(7);
   localparam logic [OCTAVE_BITS-1:0] OCT_MIN   = OCTAVE_BITS'(1);

   typedef enum logic [1:0] {IDLE, HOLD, EMIT} state_e;
   state_e state_q, state_d;

   logic [NOTE_KEYS-1:0]   key_deb, sel_q;
   logic                   up_deb, dn_deb, up_prev_q, dn_prev_q, up_rise, dn_rise;
   logic [OCTAVE_BITS-1:0] oct_q, noct_q;
   logic [NOTE_BITS-1:0]   note_q, note_sel;
   logic [CLOCK_BITS-1:0]  nclk_q;
   logic [LENGTH_BITS-1:0] len_q, unit_q;
   logic [TICK_W-1:0]      tick_q;
   logic                   one_hot, latch, emit_load;

   key_capture_deb #(.W(NOTE_KEYS), .CYC(DEBOUNCE_CYC)) u_key_deb (
      .clk(clk), .rst(rst), .raw_i(note_key), .deb_o(key_deb));
   key_capture_deb #(.W(1), .CYC(DEBOUNCE_CYC)) u_up_deb (
      .clk(clk), .rst(rst), .raw_i(oct_up), .deb_o(up_deb));
   key_capture_deb #(.W(1), .CYC(DEBOUNCE_CYC)) u_dn_deb (
      .clk(clk), .rst(rst), .raw_i(oct_down), .deb_o(dn_deb));

   assign up_rise = up_deb & ~up_prev_q;
   assign dn_rise = dn_deb & ~dn_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_prev_q <= 1'b0;
         dn_prev_q <= 1'b0;
         oct_q     <= OCT_MID;
      end else begin
         up_prev_q <= up_deb;
         dn_prev_q <= dn_deb;
         if (!en)
            oct_q <= OCT_MID;
         else if (up_rise && !dn_rise && oct_q < OCT_MAX)
            oct_q <= oct_q + OCTAVE_BITS'(1);
         else if (dn_rise && !up_rise && oct_q > OCT_MIN)
            oct_q <= oct_q - OCTAVE_BITS'(1);
      end
   end

   always_comb begin
      one_hot  = (key_deb != '0) && ((key_deb & (key_deb - 1'b1)) == '0);
      note_sel = '0;
      for (int i = 0; i < NOTE_KEYS; i++)
         if (key_deb[i]) note_sel = NOTE_BITS'(i + 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      latch     = 1'b0;
      emit_load = 1'b0;
      case (state_q)
         IDLE: if (en && one_hot) begin
            state_d = HOLD;
            latch   = 1'b1;
         end
         HOLD: if (!en) state_d = IDLE;
            else if ((key_deb & sel_q) == '0) begin
               state_d   = EMIT;
               emit_load = 1'b1;
            end
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latched record survives EMIT->IDLE and en drops; only the next press or reset changes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q  <= '0;
         note_q <= '0;
         noct_q <= '0;
         nclk_q <= '0;
         tick_q <= '0;
         unit_q <= '0;
         len_q  <= '0;
      end else begin
         if (latch) begin
            sel_q  <= key_deb;
            note_q <= note_sel;
            noct_q <= oct_q;
            nclk_q <= system_clock;
            tick_q <= '0;
            unit_q <= '0;
         end else if (state_q == HOLD) begin
            if (tick_q == TICK_LAST) begin
               tick_q <= '0;
               if (unit_q != '1) unit_q <= unit_q + LENGTH_BITS'(1);
            end else begin
               tick_q <= tick_q + TICK_W'(1);
            end
         end
         if (emit_load)
            len_q <= (unit_q == '0) ? LENGTH_BITS'(1) : unit_q;
      end
   end

   assign note_valid  = (state_q == EMIT) && en;
   assign holding     = (state_q == HOLD);
   assign octave      = oct_q;
   assign note_octave = noct_q;
   assign note        = note_q;
   assign note_clock  = nclk_q;
   assign length      = len_q;
endmodule

// File: tb/tb_key_capture.sv
// Directed bench for key_capture: a window-based behavioural model checked every
// cycle, plus hand-computed expectations for each scenario.
`timescale 1ns/1ps
module tb_key_capture;
   localparam int NK = 7, NB = 3, OB = 3, LB = 3, CB = 32, DEB = 4, TCK = 10;

   logic          clk = 1'b0, rst = 1'b1, en = 1'b1, oct_up = 1'b0, oct_down = 1'b0;
   logic [NK-1:0] note_key = '0;
   logic [CB-1:0] cyc = '0, sc_off = '0, system_clock;
   logic          note_valid, holding;
   logic [CB-1:0] note_clock;
   logic [OB-1:0] octave, note_octave;
   logic [NB-1:0] note;
   logic [LB-1:0] length;

   key_capture #(.NOTE_KEYS(NK), .NOTE_BITS(NB), .OCTAVE_BITS(OB), .LENGTH_BITS(LB),
                 .CLOCK_BITS(CB), .DEBOUNCE_CYC(DEB), .TICK_CYC(TCK)) dut (
      .clk(clk), .rst(rst), .en(en), .oct_up(oct_up), .oct_down(oct_down),
      .note_key(note_key), .system_clock(system_clock), .note_valid(note_valid),
      .note_clock(note_clock), .octave(octave), .note_octave(note_octave),
      .note(note), .length(length), .holding(holding));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign system_clock = cyc + sc_off;

   int n_vec = 0, n_bad = 0, pulses = 0, hold_cyc = 0;

   task automatic cmp(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: debounced value = delayed raw sample once DEB consecutive samples agree
   logic [NK+1:0] hist [0:DEB+1];
   logic [NK-1:0] m_key;
   logic          m_up, m_dn, m_up_p, m_dn_p;
   int            m_st, m_idx, m_entry, m_edge;
   logic [OB-1:0] m_oct, m_noct;
   logic [NB-1:0] m_note;
   logic [LB-1:0] m_len;
   logic [CB-1:0] m_nclk;

   task automatic model_reset();
      for (int i = 0; i <= DEB + 1; i++) hist[i] = '0;
      m_key = '0; m_up = 0; m_dn = 0; m_up_p = 0; m_dn_p = 0;
      m_st = 0; m_idx = 0; m_entry = 0; m_edge = 0;
      m_oct = 3'd4; m_noct = '0; m_note = '0; m_len = '0; m_nclk = '0;
   endtask

   task automatic model_step();
      bit ur, dr, same_k, same_u, same_d;
      int n, u;
      m_edge++;
      case (m_st)
         0: if (en && $onehot(m_key)) begin
               for (int i = 0; i < NK; i++) if (m_key[i]) m_idx = i;
               m_note = NB'(m_idx + 1); m_noct = m_oct; m_nclk = system_clock;
               m_entry = m_edge; m_st = 1;
            end
         1: if (!en) m_st = 0;
            else if (!m_key[m_idx]) begin
               n = m_edge - m_entry - 1;
               u = n / TCK;
               if (u > 7) u = 7;
               if (u < 1) u = 1;
               m_len = LB'(u); m_st = 2;
            end
         default: m_st = 0;
      endcase
      ur = m_up && !m_up_p;
      dr = m_dn && !m_dn_p;
      if (!en) m_oct = 3'd4;
      else if (ur && !dr && m_oct < 3'd7) m_oct = m_oct + 3'd1;
      else if (dr && !ur && m_oct > 3'd1) m_oct = m_oct - 3'd1;
      m_up_p = m_up; m_dn_p = m_dn;
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {oct_down, oct_up, note_key};
      same_k = 1; same_u = 1; same_d = 1;
      for (int i = 3; i <= DEB + 1; i++) begin
         if (hist[i][NK-1:0] != hist[2][NK-1:0]) same_k = 0;
         if (hist[i][NK] != hist[2][NK]) same_u = 0;
         if (hist[i][NK+1] != hist[2][NK+1]) same_d = 0;
      end
      if (same_k) m_key = hist[2][NK-1:0];
      if (same_u) m_up = hist[2][NK];
      if (same_d) m_dn = hist[2][NK+1];
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   initial forever begin
      @(negedge clk); #1;
      if (note_valid) pulses++;
      if (holding) hold_cyc++;
      cmp("note_valid", longint'(note_valid), longint'((m_st == 2) && en));
      cmp("holding", longint'(holding), longint'(m_st == 1));
      cmp("octave", longint'(octave), longint'(m_oct));
      cmp("note", longint'(note), longint'(m_note));
      cmp("note_octave", longint'(note_octave), longint'(m_noct));
      cmp("note_clock", longint'(note_clock), longint'(m_nclk));
      cmp("length", longint'(length), longint'(m_len));
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input string nm, input int maxc);
      bit got = 0;
      for (int i = 0; i < maxc && !got; i++) begin
         @(negedge clk); #2;
         if (note_valid) got = 1;
      end
      cmp(nm, longint'(got), 1);
   endtask

   task automatic press_oct(input logic up, input logic dn);
      oct_up = up; oct_down = dn;
      cycles(6);
      oct_up = 0; oct_down = 0;
      cycles(6);
   endtask

   int p0, h0;

   initial begin
      cycles(3);
      rst = 0;
      cycles(2); #2;
      cmp("reset octave", longint'(octave), 4);
      cmp("reset holding", longint'(holding), 0);
      cmp("reset note_clock", longint'(note_clock), 0);

      // Key bit 2 held 35 cycles, timestamp 100 at first sample
      @(negedge clk);
      sc_off = 32'd100 - cyc;
      note_key = 7'b0000100;
      cycles(35);
      note_key = '0;
      wait_pulse("pulse long press", 20);
      cmp("t1 note", longint'(note), 3);
      cmp("t1 note_octave", longint'(note_octave), 4);
      cmp("t1 note_clock", longint'(note_clock), 106);
      cmp("t1 length", longint'(length), 3);
      cycles(5);
      cmp("t1 pulse count", longint'(pulses), 1);

      // Short press and a glitch
      note_key = 7'b0001000;
      cycles(5);
      note_key = '0;
      wait_pulse("pulse short press", 20);
      cmp("t2 length", longint'(length), 1);
      cmp("t2 note", longint'(note), 4);
      cycles(5);
      h0 = hold_cyc; p0 = pulses;
      note_key = 7'b0000001;
      cycles(2);
      note_key = '0;
      cycles(15);
      cmp("glitch hold cycles", longint'(hold_cyc - h0), 0);
      cmp("glitch pulses", longint'(pulses - p0), 0);

      // Octave saturation both ways, then simultaneous presses
      repeat (10) press_oct(1, 0);
      cycles(4);
      cmp("octave up sat", longint'(octave), 7);
      repeat (10) press_oct(0, 1);
      cycles(4);
      cmp("octave down sat", longint'(octave), 1);
      press_oct(1, 0);
      cycles(4);
      cmp("octave one up", longint'(octave), 2);
      press_oct(1, 1);
      cycles(4);
      cmp("octave both", longint'(octave), 2);

      // Multi-hot press is ignored
      h0 = hold_cyc; p0 = pulses;
      note_key = 7'b0010001;
      cycles(12);
      note_key = '0;
      cycles(12);
      cmp("multihot hold cycles", longint'(hold_cyc - h0), 0);
      cmp("multihot pulses", longint'(pulses - p0), 0);

      // Hold key 1, add key 5, release key 1; key 5 then records its own note
      note_key = 7'b0000010;
      cycles(10);
      note_key = 7'b0100010;
      cycles(10);
      note_key = 7'b0100000;
      wait_pulse("pulse key1", 20);
      cmp("key1 note", longint'(note), 2);
      cmp("key1 note_octave", longint'(note_octave), 2);
      cycles(5);
      note_key = '0;
      wait_pulse("pulse key5", 25);
      cmp("key5 note", longint'(note), 6);
      cycles(5);

      // Length saturation
      note_key = 7'b1000000;
      cycles(200);
      note_key = '0;
      wait_pulse("pulse long hold", 20);
      cmp("sat length", longint'(length), 7);
      cmp("sat note", longint'(note), 7);
      cycles(5);

      // Reset mid-HOLD
      p0 = pulses;
      note_key = 7'b0000001;
      cycles(15);
      cmp("pre-rst holding", longint'(holding), 1);
      rst = 1;
      #2;
      cmp("rst holding", longint'(holding), 0);
      cmp("rst octave", longint'(octave), 4);
      cmp("rst note", longint'(note), 0);
      @(negedge clk);
      rst = 0;
      note_key = '0;
      cycles(15);
      cmp("rst pulses", longint'(pulses - p0), 0);

      // en drop mid-HOLD
      press_oct(1, 0);
      cycles(4);
      cmp("en pre octave", longint'(octave), 5);
      p0 = pulses;
      note_key = 7'b0000100;
      cycles(15);
      cmp("en pre holding", longint'(holding), 1);
      en = 0;
      @(negedge clk); #2;
      cmp("en holding", longint'(holding), 0);
      cmp("en octave", longint'(octave), 4);
      cmp("en note kept", longint'(note), 3);
      note_key = '0;
      cycles(15);
      en = 1;
      cycles(5);
      cmp("en pulses", longint'(pulses - p0), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got t=%0t expected < 200000", $time);
      $fatal(1);
   end
endmodule
